// File: rtl/sys_bus_xbar.sv
// sys_bus_xbar
//   Fixed-priority crossbar joining NrHosts bus masters to NrDevices
//   memory-mapped slaves. Requests are arbitrated and address-decoded
//   combinationally. Exactly one response is tracked, and the device
//   answers it in the cycle after the request. Addresses that match no
//   device are still granted, and they get an error response.
//
// Ports
//   IO_CLK, IO_RST_N          clock (rising edge), async active-low reset
//   host_req_i/host_gnt_o     per-host request and same-cycle grant
//   host_addr_i/we/be/wdata   per-host command fields
//   host_rvalid_o/rdata/err   per-host response, routed from the tracked device
//   device_req_o              per-device request (decoded, only while granted)
//   device_addr/we/be/wdata_o winning host's command, broadcast to all devices
//   device_rvalid/rdata/err_i per-device response
//   cfg_device_addr_base/mask per-device decode region: (addr & mask) == base
module sys_bus_xbar #(
  parameter int NrDevices    = 3,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    IO_CLK,
  input  logic                    IO_RST_N,

  input  logic                    host_req_i    [NrHosts],
  output logic                    host_gnt_o    [NrHosts],
  input  logic [AddressWidth-1:0] host_addr_i   [NrHosts],
  input  logic                    host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i  [NrHosts],
  output logic                    host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]    host_rdata_o  [NrHosts],
  output logic                    host_err_o    [NrHosts],

  output logic                    device_req_o    [NrDevices],
  output logic [AddressWidth-1:0] device_addr_o   [NrDevices],
  output logic                    device_we_o     [NrDevices],
  output logic [DataWidth/8-1:0]  device_be_o     [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o  [NrDevices],
  input  logic                    device_rvalid_i [NrDevices],
  input  logic [DataWidth-1:0]    device_rdata_i  [NrDevices],
  input  logic                    device_err_i    [NrDevices],

  input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

  localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic                    gnt_any;
  logic [HostIdxW-1:0]     gnt_idx;
  logic [AddressWidth-1:0] sel_addr;
  logic                    sel_we;
  logic [DataWidth/8-1:0]  sel_be;
  logic [DataWidth-1:0]    sel_wdata;

  logic [NrDevices-1:0]    dev_match;
  logic                    dev_hit;
  logic [DevIdxW-1:0]      dev_idx;

  logic                    resp_pending_reg;
  logic [HostIdxW-1:0]     resp_host_reg;
  logic [DevIdxW-1:0]      resp_dev_reg;
  logic                    resp_unmapped_reg;

  logic                    rsp_rvalid;
  logic [DataWidth-1:0]    rsp_rdata;
  logic                    rsp_err;

  // Fixed priority arbitration. The loop scans downwards, so the lowest
  // requesting index is the last one written and therefore wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (host_req_i[h]) begin
        gnt_any = 1'b1;
        gnt_idx = HostIdxW'(h);
      end
    end
  end

  // Command mux. gnt_idx stays 0 when nobody requests, so host 0's
  // fields drive the device buses when the bus is idle.
  always_comb begin
    sel_addr  = host_addr_i[0];
    sel_we    = host_we_i[0];
    sel_be    = host_be_i[0];
    sel_wdata = host_wdata_i[0];
    for (int h = 1; h < NrHosts; h++) begin
      if (gnt_idx == HostIdxW'(h)) begin
        sel_addr  = host_addr_i[h];
        sel_we    = host_we_i[h];
        sel_be    = host_be_i[h];
        sel_wdata = host_wdata_i[h];
      end
    end
  end

  // Address decode. Overlapping regions resolve to the lowest device index.
  generate
    for (genvar gi = 0; gi < NrDevices; gi++) begin : g_match
      assign dev_match[gi] =
        (sel_addr & cfg_device_addr_mask[gi]) == cfg_device_addr_base[gi];
    end
  endgenerate

  always_comb begin
    dev_hit = 1'b0;
    dev_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if (dev_match[d]) begin
        dev_hit = 1'b1;
        dev_idx = DevIdxW'(d);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NrDevices; gi++) begin : g_dev
      assign device_req_o[gi]   = gnt_any && dev_hit && (dev_idx == DevIdxW'(gi));
      assign device_addr_o[gi]  = sel_addr;
      assign device_we_o[gi]    = sel_we;
      assign device_be_o[gi]    = sel_be;
      assign device_wdata_o[gi] = sel_wdata;
    end

    for (genvar gi = 0; gi < NrHosts; gi++) begin : g_gnt
      assign host_gnt_o[gi] = gnt_any && (gnt_idx == HostIdxW'(gi));
    end
  endgenerate

  // Single outstanding response. It lives for exactly one cycle because
  // devices answer in the cycle after their request.
  always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      resp_pending_reg  <= 1'b0;
      resp_host_reg     <= '0;
      resp_dev_reg      <= '0;
      resp_unmapped_reg <= 1'b0;
    end else if (gnt_any) begin
      resp_pending_reg  <= 1'b1;
      resp_host_reg     <= gnt_idx;
      resp_dev_reg      <= dev_idx;
      resp_unmapped_reg <= !dev_hit;
    end else begin
      resp_pending_reg  <= 1'b0;
    end
  end

  // Select the tracked device's response.
  always_comb begin
    rsp_rvalid = device_rvalid_i[0];
    rsp_rdata  = device_rdata_i[0];
    rsp_err    = device_err_i[0];
    for (int d = 1; d < NrDevices; d++) begin
      if (resp_dev_reg == DevIdxW'(d)) begin
        rsp_rvalid = device_rvalid_i[d];
        rsp_rdata  = device_rdata_i[d];
        rsp_err    = device_err_i[d];
      end
    end
  end

  // Only the host that owns the pending response sees anything. An
  // unmapped access completes on its own with an error and zero data.
  generate
    for (genvar gi = 0; gi < NrHosts; gi++) begin : g_rsp
      logic addressed;
      assign addressed = resp_pending_reg && (resp_host_reg == HostIdxW'(gi));
      assign host_rvalid_o[gi] = addressed && (resp_unmapped_reg || rsp_rvalid);
      assign host_err_o[gi]    = addressed && (resp_unmapped_reg || rsp_err);
      assign host_rdata_o[gi]  = (addressed && !resp_unmapped_reg) ? rsp_rdata : '0;
    end
  endgenerate

endmodule

// File: tb/tb_sys_bus_xbar.sv
// tb_sys_bus_xbar
//   Directed scenarios followed by randomized traffic. A behavioural model
//   derives the expected grants, device requests and responses from the
//   arbitration and decode rules. The model is compared on every falling
//   clock edge.
module tb_sys_bus_xbar;
  localparam int NH = 2;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          IO_CLK;
  logic          IO_RST_N;
  logic          host_req_i    [NH];
  logic          host_gnt_o    [NH];
  logic [AW-1:0] host_addr_i   [NH];
  logic          host_we_i     [NH];
  logic [3:0]    host_be_i     [NH];
  logic [DW-1:0] host_wdata_i  [NH];
  logic          host_rvalid_o [NH];
  logic [DW-1:0] host_rdata_o  [NH];
  logic          host_err_o    [NH];
  logic          device_req_o    [ND];
  logic [AW-1:0] device_addr_o   [ND];
  logic          device_we_o     [ND];
  logic [3:0]    device_be_o     [ND];
  logic [DW-1:0] device_wdata_o  [ND];
  logic          device_rvalid_i [ND];
  logic [DW-1:0] device_rdata_i  [ND];
  logic          device_err_i    [ND];
  logic [AW-1:0] cfg_device_addr_base [ND];
  logic [AW-1:0] cfg_device_addr_mask [ND];

  sys_bus_xbar #(.NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) dut (
    .IO_CLK(IO_CLK), .IO_RST_N(IO_RST_N),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
    .device_err_i(device_err_i),
    .cfg_device_addr_base(cfg_device_addr_base), .cfg_device_addr_mask(cfg_device_addr_mask)
  );

  initial IO_CLK = 1'b0;
  always #5 IO_CLK = ~IO_CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Response owed in the current cycle, established by the previous cycle's grant.
  bit m_pending = 0;
  int m_host    = 0;
  int m_dev     = 0;
  bit m_unm     = 0;

  function automatic int winner();
    for (int h = 0; h < NH; h++) if (host_req_i[h]) return h;
    return -1;
  endfunction

  function automatic int decode(input logic [AW-1:0] a);
    for (int d = 0; d < ND; d++)
      if ((a & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) return d;
    return -1;
  endfunction

  always @(negedge IO_CLK) begin
    int w, hs, dv;
    bit live;
    w  = winner();
    hs = (w < 0) ? 0 : w;
    dv = decode(host_addr_i[hs]);
    for (int h = 0; h < NH; h++)
      check($sformatf("gnt%0d", h), 64'(host_gnt_o[h]), 64'(w == h));
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dreq%0d", d), 64'(device_req_o[d]), 64'(w >= 0 && dv == d));
      check($sformatf("daddr%0d", d), 64'(device_addr_o[d]), 64'(host_addr_i[hs]));
      check($sformatf("dwe%0d", d), 64'(device_we_o[d]), 64'(host_we_i[hs]));
      check($sformatf("dbe%0d", d), 64'(device_be_o[d]), 64'(host_be_i[hs]));
      check($sformatf("dwdata%0d", d), 64'(device_wdata_o[d]), 64'(host_wdata_i[hs]));
    end
    live = m_pending && IO_RST_N;
    for (int h = 0; h < NH; h++) begin
      bit               e_v, e_e;
      logic [DW-1:0]    e_d;
      e_v = 0; e_e = 0; e_d = '0;
      if (live && m_host == h) begin
        if (m_unm) begin
          e_v = 1; e_e = 1;
        end else begin
          e_v = device_rvalid_i[m_dev];
          e_e = device_err_i[m_dev];
          e_d = device_rdata_i[m_dev];
        end
      end
      check($sformatf("rvalid%0d", h), 64'(host_rvalid_o[h]), 64'(e_v));
      check($sformatf("err%0d", h), 64'(host_err_o[h]), 64'(e_e));
      check($sformatf("rdata%0d", h), 64'(host_rdata_o[h]), 64'(e_d));
    end
    // Inputs are stable from here to the next rising edge. The state
    // recorded now is therefore what that edge captures.
    if (!IO_RST_N) begin
      m_pending = 0; m_host = 0; m_dev = 0; m_unm = 0;
    end else begin
      m_pending = (w >= 0);
      if (w >= 0) begin
        m_host = w;
        m_dev  = (dv < 0) ? 0 : dv;
        m_unm  = (dv < 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge IO_CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge IO_CLK);
    #1;
  endtask

  task automatic idle();
    for (int h = 0; h < NH; h++) begin
      host_req_i[h] = 0; host_addr_i[h] = '0; host_we_i[h] = 0;
      host_be_i[h] = 4'hF; host_wdata_i[h] = '0;
    end
    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] = 0; device_rdata_i[d] = '0; device_err_i[d] = 0;
    end
  endtask

  task automatic cmd(input int h, input logic [AW-1:0] a, input logic we,
                     input logic [3:0] be, input logic [DW-1:0] wd);
    host_req_i[h] = 1; host_addr_i[h] = a; host_we_i[h] = we;
    host_be_i[h] = be; host_wdata_i[h] = wd;
  endtask

  task automatic cfg_plan();
    cfg_device_addr_base[0] = 32'h0010_0000; cfg_device_addr_mask[0] = ~32'h000F_FFFF;
    cfg_device_addr_base[1] = 32'h0002_0000; cfg_device_addr_mask[1] = ~32'h0000_FFFF;
    cfg_device_addr_base[2] = 32'h0003_0000; cfg_device_addr_mask[2] = ~32'h0000_FFFF;
  endtask

  function automatic logic [2:0] dreq_vec();
    return {device_req_o[2], device_req_o[1], device_req_o[0]};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 32'h0010_0000 | ($urandom & 32'h000F_FFFC);
      1: return 32'h0002_0000 | ($urandom & 32'h0000_FFFC);
      2: return 32'h0003_0000 | ($urandom & 32'h0000_FFFC);
      3: return 32'h0000_1000 | ($urandom & 32'h0000_0FFC);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    IO_RST_N = 0;
    idle();
    cfg_plan();
    // Reset: a device response arrives while reset is held.
    device_rvalid_i[0] = 1;
    device_rdata_i[0]  = 32'h1234_5678;
    repeat (2) @(posedge IO_CLK);
    sample();
    check("rst_rvalid0", 64'(host_rvalid_o[0]), 64'd0);
    check("rst_err0", 64'(host_err_o[0]), 64'd0);
    check("rst_rdata0", 64'(host_rdata_o[0]), 64'd0);
    step();
    IO_RST_N = 1;
    idle();

    // RAM read
    cmd(0, 32'h0010_0004, 0, 4'hF, 0);
    sample();
    check("ram_gnt", 64'(host_gnt_o[0]), 64'd1);
    check("ram_dreq", 64'(dreq_vec()), 64'b001);
    check("ram_addr", 64'(device_addr_o[0]), 64'h0010_0004);
    step();
    idle();
    device_rvalid_i[0] = 1; device_rdata_i[0] = 32'hDEAD_BEEF;
    sample();
    check("ram_rvalid", 64'(host_rvalid_o[0]), 64'd1);
    check("ram_rdata", 64'(host_rdata_o[0]), 64'hDEAD_BEEF);

    // Decode: writes to device 1 and device 2
    step();
    idle();
    cmd(0, 32'h0002_0000, 1, 4'hF, 32'h41);
    sample();
    check("dec1_dreq", 64'(dreq_vec()), 64'b010);
    check("dec1_we", 64'(device_we_o[1]), 64'd1);
    check("dec1_wdata", 64'(device_wdata_o[1]), 64'h41);
    step();
    device_rvalid_i[1] = 1;
    cmd(0, 32'h0003_0008, 1, 4'hF, 32'h42);
    sample();
    check("dec2_dreq", 64'(dreq_vec()), 64'b100);
    check("wr_rvalid", 64'(host_rvalid_o[0]), 64'd1);

    // Unmapped read
    step();
    idle();
    device_rvalid_i[2] = 1;
    cmd(0, 32'h0005_0000, 0, 4'hF, 0);
    sample();
    check("unm_gnt", 64'(host_gnt_o[0]), 64'd1);
    check("unm_dreq", 64'(dreq_vec()), 64'b000);
    step();
    idle();
    device_rdata_i[0] = 32'hFFFF_FFFF;
    sample();
    check("unm_rvalid", 64'(host_rvalid_o[0]), 64'd1);
    check("unm_err", 64'(host_err_o[0]), 64'd1);
    check("unm_rdata", 64'(host_rdata_o[0]), 64'd0);

    // Back-to-back: RAM then timer
    step();
    idle();
    cmd(0, 32'h0010_0010, 0, 4'hF, 0);
    step();
    cmd(0, 32'h0003_0000, 0, 4'hF, 0);
    device_rvalid_i[0] = 1; device_rdata_i[0] = 32'h1111_1111;
    sample();
    check("b2b_rdata0", 64'(host_rdata_o[0]), 64'h1111_1111);
    step();
    idle();
    device_rvalid_i[0] = 1; device_rdata_i[0] = 32'h3333_3333;
    device_rvalid_i[2] = 1; device_rdata_i[2] = 32'h2222_2222; device_err_i[2] = 1;
    sample();
    check("b2b_rdata2", 64'(host_rdata_o[0]), 64'h2222_2222);
    check("b2b_err2", 64'(host_err_o[0]), 64'd1);

    // Arbitration between two hosts
    step();
    idle();
    cmd(0, 32'h0010_0000, 0, 4'hF, 0);
    cmd(1, 32'h0002_0000, 1, 4'h3, 32'h99);
    sample();
    check("arb_gnt0", 64'(host_gnt_o[0]), 64'd1);
    check("arb_gnt1", 64'(host_gnt_o[1]), 64'd0);
    check("arb_dreq", 64'(dreq_vec()), 64'b001);
    step();
    idle();
    device_rvalid_i[0] = 1; device_rdata_i[0] = 32'h0000_ABCD;
    sample();
    check("arb_rvalid0", 64'(host_rvalid_o[0]), 64'd1);
    check("arb_rvalid1", 64'(host_rvalid_o[1]), 64'd0);

    // Reset in the middle of a transaction drops the response
    step();
    idle();
    cmd(1, 32'h0010_0000, 0, 4'hF, 0);
    step();
    idle();
    IO_RST_N = 0;
    device_rvalid_i[0] = 1;
    sample();
    check("midrst_rvalid1", 64'(host_rvalid_o[1]), 64'd0);
    step();
    IO_RST_N = 1;
    sample();
    check("late_rvalid1", 64'(host_rvalid_o[1]), 64'd0);

    // Randomized traffic: first the plan map, then an overlapping map
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        cfg_device_addr_base[0] = 32'h0000_0000; cfg_device_addr_mask[0] = 32'hF000_0000;
        cfg_device_addr_base[1] = 32'h0000_0000; cfg_device_addr_mask[1] = 32'h0000_0000;
        cfg_device_addr_base[2] = 32'h0000_1000; cfg_device_addr_mask[2] = ~32'h0000_0FFF;
      end
      for (int c = 0; c < 1500; c++) begin
        step();
        IO_RST_N = ($urandom_range(0, 63) != 0);
        for (int h = 0; h < NH; h++) begin
          host_req_i[h]   = ($urandom_range(0, 3) != 0);
          host_addr_i[h]  = rand_addr();
          host_we_i[h]    = 1'($urandom);
          host_be_i[h]    = 4'($urandom);
          host_wdata_i[h] = $urandom;
        end
        for (int d = 0; d < ND; d++) begin
          device_rvalid_i[d] = ($urandom_range(0, 4) != 0);
          device_rdata_i[d]  = $urandom;
          device_err_i[d]    = ($urandom_range(0, 7) == 0);
        end
      end
    end

    step();
    IO_RST_N = 1;
    idle();
    sample();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
